mem_arbiter_ctrl: RTL and testbench
===================================

# mem_arbiter_ctrl

Arbiter and sequencer sharing the single off-chip memory port between the I-cache and D-cache miss paths of the five-stage MIPS pipeline. It accepts line-fill and write-back requests from both caches and grants one at a time. It drives the memory read/write handshake, returns the line to the granted cache, and raises a pipeline stall while any miss is outstanding. It sits between the two cache controllers and the memory model, beside the main control and hazard units.

## Interface
Parameters:
- ADDR_W, 28, line address width (word address >> 2)
- LINE_W, 128, cache line width in bits

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache miss request (read only), held until i_ack
- i_addr  in  ADDR_W  I-cache line address
- i_ack  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  LINE_W  returned line
- d_req  in  1  D-cache request, held until d_ack
- d_wen  in  1  1 = write-back, 0 = line fill
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  write-back line
- d_ack  out  1  one-cycle pulse; d_rdata valid when d_wen=0
- d_rdata  out  LINE_W  returned line
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse from memory
- stall  out  1  freeze PC/IF/ID/EX/MEM registers
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE: sample requests. If only one is high, grant it. If both are high, grant the requester not served last (last_grant register, reset value = I, so D wins the first tie). Go to SERVE_I or SERVE_D, or stay in IDLE.
- SERVE_x: drive mem_read (or mem_write for D with d_wen=1). mem_addr and mem_wdata are registered at grant and held stable. On mem_ready, capture mem_rdata into the granted requester's rdata register, drop the command, and go to RESP.
- RESP: pulse the granted ack for exactly one cycle, update last_grant, and go to IDLE. Requests are not sampled in RESP.
- Requester rule: req must be low at the clock edge after its ack. A req still high in IDLE counts as a new request.
- d_wen, d_addr and d_wdata are sampled only at grant; later changes are ignored.
- mem_ready outside SERVE_x is ignored.
- stall = i_req | d_req, combinational, forced to 0 during reset.
- The i_rdata and d_rdata registers hold their value until the next capture.

## Timing
- Reset values: all outputs 0, FSM in IDLE, last_grant = I, rdata registers 0.
- Request high in IDLE at edge N: command asserted from cycle N+1.
- mem_ready at edge M: command low from M+1, ack high during cycle M+1, IDLE at M+2.
- Minimum turnaround is 3 cycles plus memory latency. Back-to-back grants are separated by at least one IDLE cycle.
- Reset asserted mid-transaction: the command drops on the next edge and no ack is issued. Memory is expected to be reset in the same cycle.
- mem_ready arriving in the same cycle a command is first asserted is accepted (zero-wait memory).

## Configuration
- MEM_ARB_PERF_EN defined: perf_stall_cnt increments by 1 every cycle stall is high, saturates at 32'hFFFF_FFFF, and clears on rst.
- MEM_ARB_PERF_EN not defined: perf_stall_cnt is tied to 0 and no counter register is built. The port is always present.

## Structure
- Shared package mem_arb_pkg holds:
  - the FSM state enum (2-bit encoding: IDLE=0, SERVE_I=1, SERVE_D=2, RESP=3),
  - the grant encoding (GNT_I=0, GNT_D=1),
  - the default ADDR_W and LINE_W constants.
- One sub-module, mem_arb_rr: two-requester round-robin pick from {req vector, last_grant}. Combinational, reused by future arbiters.
- The FSM, registers and perf counter stay in mem_arbiter_ctrl.

## Test plan
- i_req=1, i_addr=28'h0000040, memory latency 10, mem_rdata=128'hA5..A5 -> mem_read from next cycle with addr 28'h0000040; i_ack one pulse 1 cycle after mem_ready; i_rdata=A5..A5; d_ack never asserts.
- d_req=1, d_wen=1, d_addr=28'h0000123, d_wdata=128'h1234 -> mem_write=1 with mem_wdata=128'h1234; d_ack pulse; mem_read stays 0.
- i_req and d_req both rise in the same cycle after reset -> D served first, then I, one IDLE cycle between; stall stays high throughout.
- Repeated simultaneous requests over 4 transactions -> grants alternate D, I, D, I.
- rst asserted 3 cycles into a read (latency 10) -> mem_read=0 next cycle, no ack, all outputs 0, FSM in IDLE.
- With MEM_ARB_PERF_EN: a single I miss with latency 5 -> perf_stall_cnt = 8 after completion (stall high from request cycle through ack cycle). Without the macro -> perf_stall_cnt = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory-port arbiter
// Contents: FSM state enum, grant encoding, default address/line widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// rtl/mem_arbiter_ctrl_if.sv - cache-side and memory-side bus of the memory-port arbiter
// Signals: i_req/i_addr/i_ack/i_rdata (I-cache), d_req/d_wen/d_addr/d_wdata/d_ack/d_rdata
// (D-cache), mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready (memory).
// Modports: slave = arbiter side, master = caches plus memory model.
interface mem_arbiter_ctrl_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_rdata;

    logic              d_req;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ack;
    logic [LINE_W-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-requester round-robin pick
// Ports: req[0]=I, req[1]=D; last_grant = requester served most recently;
// valid = any request; gnt = chosen requester (meaningful only when valid).
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_gnt_e   last_grant,
    output logic       valid,
    output arb_gnt_e   gnt
);

    always_comb begin
        valid = |req;
        gnt   = GNT_I;
        case (req)
            2'b01:   gnt = GNT_I;
            2'b10:   gnt = GNT_D;
            // On a tie the requester that was not served last wins.
            2'b11:   gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
            default: gnt = GNT_I;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - shares the off-chip memory port between I-cache and D-cache misses
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_ctrl_if.slave), stall (pipeline
// freeze while any miss is pending), perf_stall_cnt (stall-cycle counter).
// Optional feature: MEM_ARB_PERF_EN builds the saturating stall counter; otherwise the
// counter output is tied to zero.
module mem_arbiter_ctrl
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_ctrl_if.slave   bus,
    output logic                stall,
    output logic [31:0]         perf_stall_cnt
);

    arb_state_e        state_q, state_d;
    arb_gnt_e          gnt_q;
    arb_gnt_e          last_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    logic              pick_valid;
    arb_gnt_e          pick;

    mem_arb_rr u_rr (
        .req        ({bus.d_req, bus.i_req}),
        .last_grant (last_q),
        .valid      (pick_valid),
        .gnt        (pick)
    );

    wire grant_now = (state_q == IDLE) && pick_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.i_ack     = 1'b0;
        bus.d_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = (pick == GNT_D) ? SERVE_D : SERVE_I;
            end
            SERVE_I: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = RESP;
            end
            SERVE_D: begin
                bus.mem_read  = ~wen_q;
                bus.mem_write = wen_q;
                if (bus.mem_ready) state_d = RESP;
            end
            RESP: begin
                bus.i_ack = (gnt_q == GNT_I);
                bus.d_ack = (gnt_q == GNT_D);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant-time capture of the request fields, line capture on completion,
    // and round-robin history update once the response has been delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= GNT_I;
            last_q    <= GNT_I;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant_now) begin
                gnt_q <= pick;
                if (pick == GNT_D) begin
                    wen_q   <= bus.d_wen;
                    addr_q  <= bus.d_addr;
                    wdata_q <= bus.d_wdata;
                end else begin
                    wen_q  <= 1'b0;
                    addr_q <= bus.i_addr;
                end
            end
            if (state_q == SERVE_I && bus.mem_ready) begin
                i_rdata_q <= bus.mem_rdata;
            end
            // A write-back returns no line, so d_rdata keeps its last fill.
            if (state_q == SERVE_D && bus.mem_ready && !wen_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
            if (state_q == RESP) begin
                last_q <= gnt_q;
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // Held requests mark outstanding misses; reset masks them so the pipeline
    // is never frozen while it is being reset.
    assign stall = ~rst & (bus.i_req | bus.d_req);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb/tb_mem_arbiter_ctrl.sv - self-checking bench for mem_arbiter_ctrl
module tb_mem_arbiter_ctrl;

    localparam int AW = 28;
    localparam int LW = 128;
    localparam int TMO = 300;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] perf;

    mem_arbiter_ctrl_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_arbiter_ctrl #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .stall          (stall),
        .perf_stall_cnt (perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: answers after mem_lat extra command cycles (0 = same cycle).
    int          mem_lat = 0;
    logic [LW-1:0] mem_pat = '0;
    bit          stray = 0;

    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (stray) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = {LW{1'b1}};
            end else if (!rst && (bus.mem_read || bus.mem_write)) begin
                if (cnt == mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_pat;
                    cnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Behavioural model: one transaction at a time, phase 0 = free,
    // 1 = memory command outstanding, 2 = answer being returned.
    int            m_phase = 0;
    bit            m_who_d = 0;
    bit            m_last_d = 0;
    bit            m_wen = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    logic [LW-1:0] m_irdata = '0;
    logic [LW-1:0] m_drdata = '0;
    logic [31:0]   m_perf = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_who_d  <= 0;
            m_last_d <= 0;
            m_wen    <= 0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_irdata <= '0;
            m_drdata <= '0;
            m_perf   <= '0;
        end else begin
            if ((bus.i_req || bus.d_req) && m_perf != 32'hFFFF_FFFF) m_perf <= m_perf + 1;
            if (m_phase == 0) begin
                if (bus.d_req && (!bus.i_req || !m_last_d)) begin
                    m_phase <= 1; m_who_d <= 1; m_wen <= bus.d_wen;
                    m_addr <= bus.d_addr; m_wdata <= bus.d_wdata;
                end else if (bus.i_req) begin
                    m_phase <= 1; m_who_d <= 0; m_wen <= 0; m_addr <= bus.i_addr;
                end
            end else if (m_phase == 1) begin
                if (bus.mem_ready) begin
                    m_phase <= 2;
                    if (!m_who_d) m_irdata <= bus.mem_rdata;
                    else if (!m_wen) m_drdata <= bus.mem_rdata;
                end
            end else begin
                m_last_d <= m_who_d;
                m_phase  <= 0;
            end
        end
    end

    // Compare process plus event tallies used by the directed checks.
    int            rd_cycles = 0, wr_cycles = 0, i_acks = 0, d_acks = 0, stall_low = 0;
    bit            prev_cmd = 0;
    logic [AW-1:0] gq[$];

    always @(negedge clk) begin
        chk("stall",     stall,         !rst && (bus.i_req || bus.d_req));
        chk("mem_read",  bus.mem_read,  m_phase == 1 && !m_wen);
        chk("mem_write", bus.mem_write, m_phase == 1 && m_wen);
        chk("mem_addr",  bus.mem_addr,  m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("i_ack",     bus.i_ack,     m_phase == 2 && !m_who_d);
        chk("d_ack",     bus.d_ack,     m_phase == 2 && m_who_d);
        chk("i_rdata",   bus.i_rdata,   m_irdata);
        chk("d_rdata",   bus.d_rdata,   m_drdata);
`ifdef MEM_ARB_PERF_EN
        chk("perf",      perf,          m_perf);
`else
        chk("perf",      perf,          32'd0);
`endif
        if (bus.mem_read)  rd_cycles <= rd_cycles + 1;
        if (bus.mem_write) wr_cycles <= wr_cycles + 1;
        if (bus.i_ack)     i_acks <= i_acks + 1;
        if (bus.d_ack)     d_acks <= d_acks + 1;
        if (!stall)        stall_low <= stall_low + 1;
        if ((bus.mem_read || bus.mem_write) && !prev_cmd) gq.push_back(bus.mem_addr);
        prev_cmd <= bus.mem_read || bus.mem_write;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_i(input logic [AW-1:0] a);
        int n;
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        n = 0;
        while (n < TMO) begin
            @(negedge clk);
            if (bus.i_ack) break;
            n++;
        end
        chk("i_ack_timeout", n >= TMO, 1'b0);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
    endtask

    task automatic do_d(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd);
        int n;
        bus.d_addr  = a;
        bus.d_wen   = w;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        n = 0;
        while (n < TMO) begin
            @(negedge clk);
            if (bus.d_ack) break;
            n++;
        end
        chk("d_ack_timeout", n >= TMO, 1'b0);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
    endtask

    initial begin
        int s_rd, s_wr, s_i, s_d, s_st, s_q;
        logic [LW-1:0] a5, zpat;
        a5   = {16{8'hA5}};
        zpat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_wen = 0; bus.d_addr = '0; bus.d_wdata = '0;
        cyc(3);
        chk("rst_i_rdata", bus.i_rdata, '0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_stall", stall, 1'b0);
        rst = 1'b0;
        cyc(1);

        // Single I-cache fill, latency 10.
        s_rd = rd_cycles; s_wr = wr_cycles; s_i = i_acks; s_d = d_acks; s_q = gq.size();
        mem_lat = 10; mem_pat = a5;
        do_i(28'h0000040);
        cyc(1);
        chk("t1_i_rdata", bus.i_rdata, a5);
        chk("t1_rd_cycles", rd_cycles - s_rd, 11);
        chk("t1_i_acks", i_acks - s_i, 1);
        chk("t1_d_acks", d_acks - s_d, 0);
        chk("t1_grant_addr", gq[s_q], 28'h0000040);

        // D-cache write-back, latency 3; request fields changed after grant are ignored.
        s_rd = rd_cycles; s_wr = wr_cycles; s_d = d_acks; s_q = gq.size();
        mem_lat = 3; mem_pat = '1;
        fork
            do_d(28'h0000123, 1'b1, 128'h1234);
            begin
                cyc(3);
                bus.d_wdata = 128'hDEAD;
                bus.d_addr  = 28'h0000999;
            end
        join
        cyc(1);
        chk("t2_wr_cycles", wr_cycles - s_wr, 4);
        chk("t2_rd_cycles", rd_cycles - s_rd, 0);
        chk("t2_d_acks", d_acks - s_d, 1);
        chk("t2_d_rdata", bus.d_rdata, '0);
        chk("t2_grant_addr", gq[s_q], 28'h0000123);

        // Zero-wait D-cache fill.
        s_rd = rd_cycles;
        mem_lat = 0; mem_pat = zpat;
        do_d(28'h0000055, 1'b0, '0);
        cyc(1);
        chk("t3_d_rdata", bus.d_rdata, zpat);
        chk("t3_rd_cycles", rd_cycles - s_rd, 1);
        chk("t3_i_rdata_held", bus.i_rdata, a5);

        // Stray mem_ready while idle must change nothing.
        s_i = i_acks; s_d = d_acks;
        stray = 1;
        cyc(1);
        stray = 0;
        cyc(2);
        chk("t4_i_rdata", bus.i_rdata, a5);
        chk("t4_d_rdata", bus.d_rdata, zpat);
        chk("t4_acks", (i_acks - s_i) + (d_acks - s_d), 0);

        // Ties after reset alternate D, I, D, I.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        mem_lat = 2; mem_pat = 128'h77;
        s_q = gq.size(); s_st = stall_low;
        repeat (2) begin
            fork
                do_d(28'h0000300, 1'b0, '0);
                do_i(28'h0000200);
            join
        end
        chk("t5_stall_low", stall_low - s_st, 0);
        cyc(1);
        chk("t5_grants", gq.size() - s_q, 4);
        if (gq.size() - s_q >= 4) begin
            chk("t5_g0", gq[s_q],     28'h0000300);
            chk("t5_g1", gq[s_q + 1], 28'h0000200);
            chk("t5_g2", gq[s_q + 2], 28'h0000300);
            chk("t5_g3", gq[s_q + 3], 28'h0000200);
        end

        // Reset three cycles into a latency-10 read.
        mem_lat = 10;
        s_i = i_acks;
        bus.i_addr = 28'h0000077;
        bus.i_req  = 1'b1;
        cyc(1);
        cyc(3);
        rst = 1'b1;
        bus.i_req = 1'b0;
        cyc(1);
        chk("t6_mem_read", bus.mem_read, 1'b0);
        chk("t6_mem_addr", bus.mem_addr, '0);
        chk("t6_i_rdata", bus.i_rdata, '0);
        chk("t6_stall", stall, 1'b0);
        rst = 1'b0;
        cyc(12);
        chk("t6_no_ack", i_acks - s_i, 0);

        // Stall-cycle counter for a single I miss with latency 5.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        mem_lat = 5;
        do_i(28'h0000010);
`ifdef MEM_ARB_PERF_EN
        chk("t7_perf", perf, 32'd8);
`else
        chk("t7_perf", perf, 32'd0);
`endif
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
